// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: operation codes, FSM states
// and a small sign-extension helper used by the word variants.
package div_pkg;

  // Operation codes. Bit 2 selects the 32-bit word form, bit 1 selects the
  // remainder instead of the quotient, bit 0 selects unsigned operands.
  localparam logic [2:0] DO_DIV   = 3'd0;
  localparam logic [2:0] DO_DIVU  = 3'd1;
  localparam logic [2:0] DO_REM   = 3'd2;
  localparam logic [2:0] DO_REMU  = 3'd3;
  localparam logic [2:0] DO_DIVW  = 3'd4;
  localparam logic [2:0] DO_DIVUW = 3'd5;
  localparam logic [2:0] DO_REMW  = 3'd6;
  localparam logic [2:0] DO_REMUW = 3'd7;

  // Most negative dividends for the signed-overflow check (word form is
  // already sign-extended when compared).
  localparam logic [63:0] DWORD_MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] WORD_MIN  = 64'hFFFF_FFFF_8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for the RV64M divide/remainder group.
// Handshake: a request transfers on a clock edge where req_valid && req_ready;
// a response transfers on an edge where resp_valid && resp_ready, and while
// resp_valid is high and resp_ready is low the result is held stable.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] operand1,
  input  logic [63:0] operand2,
  input  logic [2:0]  div_op,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [63:0] resp_result,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [1:0]  dbg_state
);

  div_state_e  state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  // The stored partial remainder is always below the divisor, so bit 64 of
  // the 65-bit trial difference is zero whenever it is kept; only 64 bits
  // need storing.
  logic [63:0] rem_q, rem_d;
  logic [63:0] quo_q, quo_d;
  logic [63:0] dsr_q, dsr_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        op_rem_q, op_rem_d;
  logic        op_word_q, op_word_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_result_q, resp_result_d;

  logic        accept;
  logic        is_word, is_uns, is_rem;
  logic [63:0] a_eff, b_eff, a_abs, b_abs;
  logic        s1, s2, by_zero, overflow;
  logic [63:0] special_res;
  logic [64:0] trial;
  logic [63:0] quo_fix, rem_fix, fix_sel, fix_res;

  assign req_ready   = (state_q == ST_IDLE) && (!resp_valid_q || resp_ready);
  assign accept      = req_valid && req_ready;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign dbg_state   = state_q;

  assign is_word = div_op[2];
  assign is_rem  = div_op[1];
  assign is_uns  = div_op[0];

  // Operand decode and single-cycle special-case results, evaluated at accept.
  always_comb begin
    a_eff = operand1;
    b_eff = operand2;
    if (is_word) begin
      a_eff = is_uns ? {32'd0, operand1[31:0]} : sext32(operand1[31:0]);
      b_eff = is_uns ? {32'd0, operand2[31:0]} : sext32(operand2[31:0]);
    end
    s1       = !is_uns && a_eff[63];
    s2       = !is_uns && b_eff[63];
    a_abs    = s1 ? (64'd0 - a_eff) : a_eff;
    b_abs    = s2 ? (64'd0 - b_eff) : b_eff;
    by_zero  = (b_eff == 64'd0);
    overflow = !is_uns && (b_eff == {64{1'b1}}) &&
               (a_eff == (is_word ? WORD_MIN : DWORD_MIN));
    if (by_zero) begin
      special_res = is_rem ? a_eff : {64{1'b1}};
      if (is_word) special_res = sext32(special_res[31:0]);
    end else begin
      // Overflow: quotient is the (already sign-extended) dividend, remainder 0.
      special_res = is_rem ? 64'd0 : a_eff;
    end
  end

  // One restoring step and the final sign fix-up / result selection.
  always_comb begin
    trial   = {rem_q, quo_q[63]} - {1'b0, dsr_q};
    quo_fix = neg_quo_q ? (64'd0 - quo_q) : quo_q;
    rem_fix = neg_rem_q ? (64'd0 - rem_q) : rem_q;
    fix_sel = op_rem_q ? rem_fix : quo_fix;
    fix_res = op_word_q ? sext32(fix_sel[31:0]) : fix_sel;
  end

  // Registers: FSM state, datapath and the held response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 7'd0;
      rem_q         <= 64'd0;
      quo_q         <= 64'd0;
      dsr_q         <= 64'd0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      op_rem_q      <= 1'b0;
      op_word_q     <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= 64'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dsr_q         <= dsr_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      op_rem_q      <= op_rem_d;
      op_word_q     <= op_word_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
    end
  end

  // Next-state logic: special cases never leave IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && !by_zero && !overflow) state_d = ST_ITER;
      ST_ITER: if (cnt_q == 7'd1) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and response updates per state.
  always_comb begin
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dsr_d         = dsr_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    op_rem_d      = op_rem_q;
    op_word_d     = op_word_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    case (state_q)
      ST_IDLE: begin
        if (resp_ready) resp_valid_d = 1'b0;
        if (accept) begin
          op_rem_d  = is_rem;
          op_word_d = is_word;
          neg_quo_d = s1 ^ s2;
          neg_rem_d = s1;
          // Word dividends are left-aligned so 32 steps consume them fully.
          quo_d     = is_word ? {a_abs[31:0], 32'd0} : a_abs;
          dsr_d     = b_abs;
          rem_d     = 64'd0;
          cnt_d     = is_word ? 7'd32 : 7'd64;
          if (by_zero || overflow) begin
            resp_valid_d  = 1'b1;
            resp_result_d = special_res;
          end
        end
      end
      ST_ITER: begin
        if (!trial[64]) begin
          rem_d = trial[63:0];
          quo_d = {quo_q[62:0], 1'b1};
        end else begin
          rem_d = {rem_q[62:0], quo_q[63]};
          quo_d = {quo_q[62:0], 1'b0};
        end
        cnt_d = cnt_q - 7'd1;
      end
      ST_FIX: begin
        resp_valid_d  = 1'b1;
        resp_result_d = fix_res;
      end
      default: ;
    endcase
  end

endmodule
